// File: rtl/syscall_unit.sv
// syscall_unit: services the MIPS syscall instruction (print_int, print_string,
// print_char, exit). Stalls the core while a service runs, fetches string bytes
// through a request/valid memory port and streams characters out.
//
// Output handshake: out_valid/out_data are driven from registered state only;
// a character moves on a rising edge where out_valid and out_ready are both
// high, and out_data holds steady while out_valid is high and out_ready is low.
module syscall_unit #(
   parameter int MAX_STR = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        syscall,
   input  logic [31:0] sys_call_reg,
   input  logic [31:0] std_out_address,
   output logic        mem_rd,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   input  logic        mem_rvalid,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        stall,
   output logic        halt,
   output logic        err
);

   localparam int CW = $clog2(MAX_STR + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_INT_SIGN, S_INT_DIG, S_INT_EMIT,
      S_STR_REQ, S_STR_WAIT, S_STR_EMIT, S_CHAR_EMIT, S_HALTED
   } state_t;

   state_t         state_q, state_d;
   logic [31:0]    arg_q, arg_d;
   logic [31:0]    mag_q, mag_d;
   logic [3:0]     digit_q, digit_d;
   logic [3:0]     k_q, k_d;
   logic           started_q, started_d;
   logic [31:0]    ptr_q, ptr_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [7:0]     byte_q, byte_d;
   logic           err_q, err_d;
   logic [7:0]     rd_byte;
   logic [31:0]    pow_k;
   logic           code_ok;

   // Decimal weight of the digit currently being computed.
   function automatic logic [31:0] pow10(input logic [3:0] k);
      case (k)
         4'd0:    pow10 = 32'd1;
         4'd1:    pow10 = 32'd10;
         4'd2:    pow10 = 32'd100;
         4'd3:    pow10 = 32'd1000;
         4'd4:    pow10 = 32'd10000;
         4'd5:    pow10 = 32'd100000;
         4'd6:    pow10 = 32'd1000000;
         4'd7:    pow10 = 32'd10000000;
         4'd8:    pow10 = 32'd100000000;
         4'd9:    pow10 = 32'd1000000000;
         default: pow10 = 32'd1;
      endcase
   endfunction

   assign code_ok = (sys_call_reg == 32'd1) | (sys_call_reg == 32'd4) |
                    (sys_call_reg == 32'd10) | (sys_call_reg == 32'd11);
   assign rd_byte = mem_rdata[{ptr_q[1:0], 3'b000} +: 8];
   assign pow_k   = pow10(k_q);
   assign err     = err_q;

   // State and datapath registers; reset aborts any service and clears halt.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= S_IDLE;
         arg_q     <= '0;
         mag_q     <= '0;
         digit_q   <= '0;
         k_q       <= '0;
         started_q <= 1'b0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         byte_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         arg_q     <= arg_d;
         mag_q     <= mag_d;
         digit_q   <= digit_d;
         k_q       <= k_d;
         started_q <= started_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         byte_q    <= byte_d;
         err_q     <= err_d;
      end
   end

   // Next-state, datapath updates and outputs of the service sequencer.
   always_comb begin
      state_d   = state_q;
      arg_d     = arg_q;
      mag_d     = mag_q;
      digit_d   = digit_q;
      k_d       = k_q;
      started_d = started_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      byte_d    = byte_q;
      err_d     = 1'b0;
      out_valid = 1'b0;
      out_data  = 8'h00;
      mem_rd    = 1'b0;
      mem_addr  = 32'h0;
      stall     = (state_q != S_IDLE);
      halt      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (syscall) begin
               stall = code_ok;
               arg_d = std_out_address;
               case (sys_call_reg)
                  32'd1:   state_d = S_INT_SIGN;
                  32'd4: begin
                     ptr_d   = std_out_address;
                     cnt_d   = '0;
                     state_d = S_STR_REQ;
                  end
                  32'd11:  state_d = S_CHAR_EMIT;
                  32'd10:  state_d = S_HALTED;
                  default: err_d = 1'b1;
               endcase
            end
         end
         S_INT_SIGN: begin
            k_d       = 4'd9;
            digit_d   = 4'd0;
            started_d = 1'b0;
            if (arg_q[31]) begin
               out_valid = 1'b1;
               out_data  = 8'h2D;
               if (out_ready) begin
                  mag_d   = -arg_q;
                  state_d = S_INT_DIG;
               end
            end else begin
               mag_d   = arg_q;
               state_d = S_INT_DIG;
            end
         end
         S_INT_DIG: begin
            // Repeated subtraction: one weight per cycle until mag < 10^k.
            if (mag_q >= pow_k) begin
               mag_d   = mag_q - pow_k;
               digit_d = digit_q + 4'd1;
            end else if (digit_q == 4'd0 && !started_q && k_q != 4'd0) begin
               k_d = k_q - 4'd1;
            end else begin
               state_d = S_INT_EMIT;
            end
         end
         S_INT_EMIT: begin
            out_valid = 1'b1;
            out_data  = 8'h30 + {4'h0, digit_q};
            if (out_ready) begin
               started_d = 1'b1;
               digit_d   = 4'd0;
               if (k_q == 4'd0) begin
                  state_d = S_IDLE;
               end else begin
                  k_d     = k_q - 4'd1;
                  state_d = S_INT_DIG;
               end
            end
         end
         S_STR_REQ: begin
            mem_rd   = 1'b1;
            mem_addr = ptr_q;
            state_d  = S_STR_WAIT;
         end
         S_STR_WAIT: begin
            if (mem_rvalid) begin
               if (rd_byte == 8'h00 || cnt_q == CW'(MAX_STR)) begin
                  state_d = S_IDLE;
               end else begin
                  byte_d  = rd_byte;
                  state_d = S_STR_EMIT;
               end
            end
         end
         S_STR_EMIT: begin
            out_valid = 1'b1;
            out_data  = byte_q;
            if (out_ready) begin
               ptr_d   = ptr_q + 32'd1;
               cnt_d   = cnt_q + CW'(1);
               state_d = S_STR_REQ;
            end
         end
         S_CHAR_EMIT: begin
            out_valid = 1'b1;
            out_data  = arg_q[7:0];
            if (out_ready) state_d = S_IDLE;
         end
         S_HALTED: begin
            halt = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_syscall_unit.sv
// Bench for syscall_unit: randomized services checked against a string-level
// model (decimal formatting, byte-addressed memory walk).
module tb_syscall_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        syscall = 1'b0, syscall2 = 1'b0;
   logic [31:0] sys_call_reg = '0, std_out_address = '0;
   logic [31:0] mem_rdata = '0;
   logic        mem_rvalid = 1'b0;
   logic        out_ready = 1'b1;
   logic        mem_rd, mem_rd2, out_valid, out_valid2;
   logic [31:0] mem_addr, mem_addr2;
   logic [7:0]  out_data, out_data2;
   logic        stall, stall2, halt, halt2, err, err2;

   int vectors = 0;
   int miscompares = 0;
   int err_cnt = 0;
   int mem_lat = 1;
   bit rdy_rand = 1'b0;

   logic [7:0]  got_q[$], got2_q[$], exp_q[$];
   logic [31:0] mem[int unsigned];

   syscall_unit dut (
      .clk(clk), .rst(rst), .syscall(syscall), .sys_call_reg(sys_call_reg),
      .std_out_address(std_out_address), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .stall(stall), .halt(halt),
      .err(err)
   );

   syscall_unit #(.MAX_STR(2)) dut2 (
      .clk(clk), .rst(rst), .syscall(syscall2), .sys_call_reg(sys_call_reg),
      .std_out_address(std_out_address), .mem_rd(mem_rd2), .mem_addr(mem_addr2),
      .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .out_data(out_data2),
      .out_valid(out_valid2), .out_ready(out_ready), .stall(stall2), .halt(halt2),
      .err(err2)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1);
   end

   // ---------------- memory model ----------------
   function automatic logic [31:0] rd_word(input logic [31:0] a);
      if (mem.exists(a >> 2)) return mem[a >> 2];
      return 32'h0;
   endfunction

   function automatic logic [7:0] mem_byte(input logic [31:0] a);
      logic [31:0] w;
      w = rd_word(a);
      return 8'((w >> (8 * (a % 4))) & 32'hFF);
   endfunction

   function automatic void put_byte(input logic [31:0] a, input logic [7:0] b);
      logic [31:0] w;
      logic [31:0] m;
      w = rd_word(a);
      m = 32'hFF << (8 * (a % 4));
      w = (w & ~m) | ({24'h0, b} << (8 * (a % 4)));
      mem[a >> 2] = w;
   endfunction

   function automatic void place_str(input logic [31:0] a, input int len);
      put_byte(a - 32'd1, 8'($urandom_range(1, 255)));
      for (int i = 0; i < len; i++) put_byte(a + 32'(i), 8'($urandom_range(1, 255)));
      put_byte(a + 32'(len), 8'h00);
   endfunction

   // Responds to a read request seen on either unit after mem_lat cycles.
   always begin
      logic [31:0] a;
      @(negedge clk);
      if (mem_rd === 1'b1 || mem_rd2 === 1'b1) begin
         a = (mem_rd === 1'b1) ? mem_addr : mem_addr2;
         repeat (mem_lat) @(posedge clk);
         #1;
         mem_rdata  = rd_word(a);
         mem_rvalid = 1'b1;
         @(posedge clk);
         #1;
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
      end
   end

   // Sink backpressure when randomized.
   always @(posedge clk) begin
      #1;
      if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
   end

   // ---------------- monitor ----------------
   logic       prev_v = 1'b0, prev_r = 1'b0;
   logic [7:0] prev_d = 8'h00;
   always @(negedge clk) begin
      if (rst) begin
         prev_v = 1'b0;
      end else begin
         if (prev_v && !prev_r) begin
            vectors++;
            if (out_valid !== 1'b1 || out_data !== prev_d) begin
               miscompares++;
               $display("FAIL hold_stable: valid=%b data=%h, required valid=1 data=%h",
                        out_valid, out_data, prev_d);
            end
         end
         if (out_valid === 1'b1 && out_ready === 1'b1) got_q.push_back(out_data);
         if (out_valid2 === 1'b1 && out_ready === 1'b1) got2_q.push_back(out_data2);
         if (err === 1'b1) err_cnt++;
         prev_v = out_valid;
         prev_r = out_ready;
         prev_d = out_data;
      end
   end

   // ---------------- reference model ----------------
   function automatic void exp_int(input logic [31:0] v);
      string s;
      s = $sformatf("%0d", $signed(v));
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
   endfunction

   function automatic void exp_str(input logic [31:0] a, input int maxn);
      logic [7:0]  b;
      logic [31:0] p;
      p = a;
      for (int n = 0; n < maxn; n++) begin
         b = mem_byte(p);
         if (b == 8'h00) break;
         exp_q.push_back(b);
         p = p + 32'd1;
      end
   endfunction

   function automatic string q2s(input logic [7:0] q[$]);
      string s;
      s = "";
      foreach (q[i]) s = {s, $sformatf("%02h", q[i])};
      if (q.size() == 0) s = "empty";
      return s;
   endfunction

   // ---------------- driver tasks ----------------
   // Called one step after a rising edge with the unit idle.
   task automatic start_service(input logic [31:0] code, input logic [31:0] arg,
                                output int sc);
      sys_call_reg    = code;
      std_out_address = arg;
      syscall         = 1'b1;
      sc              = 0;
      @(negedge clk);
      if (stall === 1'b1) sc++;
      @(posedge clk);
      #1;
      syscall = 1'b0;
   endtask

   task automatic wait_idle(inout int sc);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (stall === 1'b1) sc++;
         else begin
            done = 1'b1;
            break;
         end
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL idle_timeout: stall=%b after 3000 cycles, required 0", stall);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic flush();
      got_q.delete();
      got2_q.delete();
      exp_q.delete();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      vectors++;
      if ({stall, err, mem_rd, out_valid} !== 4'b0000) begin
         miscompares++;
         $display("FAIL reset_ctrl: stall/err/mem_rd/out_valid=%b, required 0000",
                  {stall, err, mem_rd, out_valid});
      end
      vectors++;
      if (halt !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_halt: halt=%b, required 0", halt);
      end
      vectors++;
      if ({out_data, mem_addr} !== 40'h0) begin
         miscompares++;
         $display("FAIL reset_data: out_data=%h mem_addr=%h, required 00 00000000",
                  out_data, mem_addr);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_print_char();
      int sc;
      rdy_rand  = 1'b0;
      out_ready = 1'b1;
      flush();
      exp_q.push_back(8'h41);
      start_service(32'd11, 32'h41, sc);
      wait_idle(sc);
      vectors++;
      if (q2s(got_q) != q2s(exp_q)) begin
         miscompares++;
         $display("FAIL print_char_out: got %s, required %s", q2s(got_q), q2s(exp_q));
      end
      vectors++;
      if (sc != 2) begin
         miscompares++;
         $display("FAIL print_char_stall: stall cycles %0d, required 2", sc);
      end
   endtask

   task automatic test_print_int();
      int          sc;
      logic [31:0] vals[$];
      vals = '{32'hFFFF_FECF, 32'd0, 32'h8000_0000, 32'h7FFF_FFFF, 32'd9, 32'd10,
               32'd1000000000, 32'hFFFF_FFFF};
      for (int i = 0; i < 6; i++) vals.push_back($urandom);
      rdy_rand = 1'b1;
      foreach (vals[i]) begin
         flush();
         exp_int(vals[i]);
         start_service(32'd1, vals[i], sc);
         wait_idle(sc);
         vectors++;
         if (q2s(got_q) != q2s(exp_q)) begin
            miscompares++;
            $display("FAIL print_int(%0d): got %s, required %s", $signed(vals[i]),
                     q2s(got_q), q2s(exp_q));
         end
      end
      rdy_rand  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_int_hold();
      int sc;
      rdy_rand  = 1'b0;
      out_ready = 1'b1;
      flush();
      exp_int(32'hFFFF_FECF);
      start_service(32'd1, 32'hFFFF_FECF, sc);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (got_q.size() >= 2) break;
      end
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      repeat (5) @(negedge clk);
      vectors++;
      if (out_valid !== 1'b1 || out_data !== exp_q[2] || got_q.size() != 2) begin
         miscompares++;
         $display("FAIL int_hold: valid=%b data=%h count=%0d, required 1 %h 2",
                  out_valid, out_data, got_q.size(), exp_q[2]);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      wait_idle(sc);
      vectors++;
      if (q2s(got_q) != q2s(exp_q)) begin
         miscompares++;
         $display("FAIL int_hold_out: got %s, required %s", q2s(got_q), q2s(exp_q));
      end
   endtask

   task automatic test_print_string();
      int          sc;
      int          len;
      logic [31:0] a;
      rdy_rand  = 1'b0;
      out_ready = 1'b1;
      mem_lat   = 1;
      mem[32'h100 >> 2] = 32'h0021_6948;
      // aligned start, three chars at 3 cycles each plus final fetch
      flush();
      exp_str(32'h100, 256);
      start_service(32'd4, 32'h100, sc);
      wait_idle(sc);
      vectors++;
      if (q2s(got_q) != q2s(exp_q)) begin
         miscompares++;
         $display("FAIL str_0x100: got %s, required %s", q2s(got_q), q2s(exp_q));
      end
      vectors++;
      if (sc != 1 + 3 * 3 + 2) begin
         miscompares++;
         $display("FAIL str_stall: stall cycles %0d, required %0d", sc, 1 + 3 * 3 + 2);
      end
      // unaligned start
      flush();
      exp_str(32'h101, 256);
      start_service(32'd4, 32'h101, sc);
      wait_idle(sc);
      vectors++;
      if (q2s(got_q) != q2s(exp_q)) begin
         miscompares++;
         $display("FAIL str_0x101: got %s, required %s", q2s(got_q), q2s(exp_q));
      end
      // truncation on the MAX_STR=2 instance
      flush();
      exp_str(32'h100, 2);
      sys_call_reg    = 32'd4;
      std_out_address = 32'h100;
      syscall2        = 1'b1;
      @(negedge clk);
      @(posedge clk);
      #1;
      syscall2 = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (stall2 !== 1'b1) break;
      end
      @(posedge clk);
      #1;
      vectors++;
      if (q2s(got2_q) != q2s(exp_q)) begin
         miscompares++;
         $display("FAIL str_max2: got %s, required %s", q2s(got2_q), q2s(exp_q));
      end
      // random strings, including one wrapping past 0xFFFFFFFF
      rdy_rand = 1'b1;
      for (int t = 0; t < 5; t++) begin
         a   = (t == 0) ? 32'hFFFF_FFFE : 32'h1000 + 32'($urandom_range(0, 255)) * 32'd17;
         len = (t == 0) ? 4 : $urandom_range(0, 8);
         place_str(a, len);
         mem_lat = $urandom_range(1, 3);
         flush();
         exp_str(a, 256);
         start_service(32'd4, a, sc);
         wait_idle(sc);
         vectors++;
         if (q2s(got_q) != q2s(exp_q)) begin
            miscompares++;
            $display("FAIL str_rand@%h: got %s, required %s", a, q2s(got_q), q2s(exp_q));
         end
      end
      rdy_rand  = 1'b0;
      out_ready = 1'b1;
      mem_lat   = 1;
   endtask

   task automatic test_unsupported();
      int          e0;
      logic [31:0] codes[$];
      codes = '{32'd7, 32'd0, 32'd2, 32'd12, 32'h8000_0001};
      foreach (codes[i]) begin
         flush();
         e0 = err_cnt;
         sys_call_reg    = codes[i];
         std_out_address = $urandom;
         syscall         = 1'b1;
         @(negedge clk);
         vectors++;
         if (stall !== 1'b0) begin
            miscompares++;
            $display("FAIL unsup_stall(%0d): stall=%b, required 0", codes[i], stall);
         end
         @(posedge clk);
         #1;
         syscall = 1'b0;
         repeat (3) @(negedge clk);
         vectors++;
         if (err_cnt - e0 != 1 || got_q.size() != 0) begin
            miscompares++;
            $display("FAIL unsup_err(%0d): err cycles %0d chars %0d, required 1 and 0",
                     codes[i], err_cnt - e0, got_q.size());
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_exit();
      int sc;
      int e0;
      flush();
      e0 = err_cnt;
      start_service(32'd10, 32'd0, sc);
      for (int i = 0; i < 20; i++) begin
         syscall      = 1'($urandom_range(0, 1));
         sys_call_reg = 32'($urandom_range(0, 12));
         @(negedge clk);
         vectors++;
         if ({halt, stall, out_valid, mem_rd} !== 4'b1100) begin
            miscompares++;
            $display("FAIL exit_halted: halt/stall/out_valid/mem_rd=%b, required 1100",
                     {halt, stall, out_valid, mem_rd});
         end
         @(posedge clk);
         #1;
      end
      syscall = 1'b0;
      vectors++;
      if (err_cnt != e0 || got_q.size() != 0) begin
         miscompares++;
         $display("FAIL exit_quiet: err cycles %0d chars %0d, required 0 and 0",
                  err_cnt - e0, got_q.size());
      end
      #1;
      rst = 1'b1;
      #1;
      vectors++;
      if (halt !== 1'b0 || stall !== 1'b0) begin
         miscompares++;
         $display("FAIL exit_reset: halt=%b stall=%b, required 0 0", halt, stall);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      flush();
      exp_q.push_back(8'h42);
      start_service(32'd11, 32'h42, sc);
      wait_idle(sc);
      vectors++;
      if (q2s(got_q) != q2s(exp_q)) begin
         miscompares++;
         $display("FAIL exit_then_char: got %s, required %s", q2s(got_q), q2s(exp_q));
      end
   endtask

   task automatic test_reset_mid_string();
      int sc;
      place_str(32'h200, 20);
      rdy_rand = 1'b1;
      mem_lat  = 1;
      flush();
      exp_str(32'h200, 256);
      start_service(32'd4, 32'h200, sc);
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (got_q.size() >= 3) break;
      end
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      vectors++;
      if (out_valid !== 1'b0 || stall !== 1'b0 || mem_rd !== 1'b0) begin
         miscompares++;
         $display("FAIL abort_now: out_valid=%b stall=%b mem_rd=%b, required 0 0 0",
                  out_valid, stall, mem_rd);
      end
      while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
      vectors++;
      if (q2s(got_q) != q2s(exp_q) || got_q.size() < 3) begin
         miscompares++;
         $display("FAIL abort_prefix: got %s, required prefix %s", q2s(got_q), q2s(exp_q));
      end
      @(posedge clk);
      #1;
      rst      = 1'b0;
      rdy_rand = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      flush();
      exp_q.push_back(8'h5A);
      start_service(32'd11, 32'h5A, sc);
      wait_idle(sc);
      repeat (3) @(negedge clk);
      vectors++;
      if (q2s(got_q) != q2s(exp_q)) begin
         miscompares++;
         $display("FAIL after_abort_char: got %s, required %s", q2s(got_q), q2s(exp_q));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_back_to_back();
      int          sc;
      int          kind;
      int          e0;
      logic [31:0] a;
      rdy_rand = 1'b1;
      for (int t = 0; t < 12; t++) begin
         kind    = $urandom_range(0, 3);
         mem_lat = $urandom_range(1, 2);
         flush();
         e0 = err_cnt;
         case (kind)
            0: begin
               a = $urandom;
               exp_q.push_back(a[7:0]);
               start_service(32'd11, a, sc);
            end
            1: begin
               a = $urandom;
               exp_int(a);
               start_service(32'd1, a, sc);
            end
            2: begin
               a = 32'h3000 + 32'($urandom_range(0, 63)) * 32'd13;
               place_str(a, $urandom_range(0, 6));
               exp_str(a, 256);
               start_service(32'd4, a, sc);
            end
            default: begin
               start_service(32'd7, $urandom, sc);
            end
         endcase
         wait_idle(sc);
         vectors++;
         if (q2s(got_q) != q2s(exp_q) || (err_cnt - e0) != ((kind == 3) ? 1 : 0)) begin
            miscompares++;
            $display("FAIL b2b[%0d] kind %0d: got %s err %0d, required %s err %0d", t, kind,
                     q2s(got_q), err_cnt - e0, q2s(exp_q), (kind == 3) ? 1 : 0);
         end
      end
      rdy_rand  = 1'b0;
      out_ready = 1'b1;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_print_char();
      test_print_int();
      test_int_hold();
      test_print_string();
      test_unsupported();
      test_exit();
      test_reset_mid_string();
      test_back_to_back();
      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/syscall_unit.md
# syscall_unit

Services the MIPS `syscall` instruction by consuming the `$v0` service code and `$a0` argument exported by the register file on `sys_call_reg` and `std_out_address`. It stalls the core while a service runs, reads strings from data memory through a simple request/valid port, and emits characters on a ready/valid byte stream. It decodes print_int, print_string, print_char and exit, and latches a sticky halt on exit.

## Interface

Parameters:

- `MAX_STR`, default 256: maximum number of characters emitted by one print_string; the string is truncated at this length.

Ports:

- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `rst` input, 1 bit: reset, asynchronous and active-high.
- `syscall` input, 1 bit: the decoded instruction is `syscall`; held high by control until `stall` drops.
- `sys_call_reg` input, 32 bits: `$v0`, the service code.
- `std_out_address` input, 32 bits: `$a0`, the argument (integer, string address or character).
- `mem_rd` output, 1 bit: data-memory read request, one-cycle pulse.
- `mem_addr` output, 32 bits: byte address of the read; memory uses `mem_addr[31:2]`.
- `mem_rdata` input, 32 bits: read word, valid when `mem_rvalid` is high.
- `mem_rvalid` input, 1 bit: read data valid, arriving at least 1 cycle after `mem_rd`.
- `out_data` output, 8 bits: ASCII character.
- `out_valid` output, 1 bit: `out_data` is valid.
- `out_ready` input, 1 bit: the sink accepts the character.
- `stall` output, 1 bit: freezes PC and pipeline advance.
- `halt` output, 1 bit: sticky; set by exit.
- `err` output, 1 bit: one-cycle pulse for an unsupported service code.

## Operation

- States: IDLE, INT_SIGN, INT_DIG, INT_EMIT, STR_REQ, STR_WAIT, STR_EMIT, CHAR_EMIT, HALTED.
- In IDLE with `syscall` high, the unit latches `code = sys_call_reg` and `arg = std_out_address`, then dispatches on the latched code at the same edge:
  - 1 (print_int): go to INT_SIGN.
  - 4 (print_string): go to STR_REQ with `ptr = arg` and `cnt = 0`.
  - 11 (print_char): go to CHAR_EMIT.
  - 10 (exit): go to HALTED.
  - Any other code: pulse `err` and stay in IDLE.
- print_int:
  - INT_SIGN: if `arg[31]` is set, emit '-' (0x2D) and set `mag = -arg`; otherwise set `mag = arg` and emit nothing. `mag` is unsigned 32-bit, so 0x80000000 gives 2147483648.
  - INT_DIG, for k = 9 down to 0: each cycle, if `mag >= 10^k` then subtract 10^k and increment `digit`; otherwise the digit is complete.
  - A completed digit goes to INT_EMIT (char `0x30 + digit`) unless it is a leading zero. Digit k = 0 is always emitted, so 0 prints "0".
  - After digit k = 0 is accepted, return to IDLE.
- print_string:
  - STR_REQ: pulse `mem_rd` with `mem_addr = ptr`.
  - STR_WAIT: wait for `mem_rvalid`, then extract the little-endian byte `mem_rdata[8*ptr[1:0] +: 8]`.
  - If the byte is 0x00, or `cnt == MAX_STR`, return to IDLE. Otherwise go to STR_EMIT.
  - When the byte is accepted, increment `ptr` and `cnt` and go back to STR_REQ.
  - `ptr` wraps modulo 2^32.
- print_char: emit `arg[7:0]`, then return to IDLE.
- HALTED: terminal until `rst`; `halt` = 1, `stall` = 1, no outputs.
- Output handshake:
  - `out_valid` is high only in INT_SIGN (negative case), INT_EMIT, STR_EMIT and CHAR_EMIT.
  - `out_data` is stable while `out_valid` is high and `out_ready` is low.
  - A transfer occurs on a rising edge with both high.
  - `out_valid` does not depend combinationally on `out_ready`.

## Timing

- Reset values: state IDLE; `stall`, `halt`, `err`, `mem_rd`, `out_valid` = 0; `out_data` = 0; `mem_addr` = 0. `rst` mid-service aborts immediately with no further transfers, and also clears `halt`.
- `stall` = (state != IDLE) | (state == IDLE & `syscall` & code not unsupported). It is combinational, so the core freezes in the same cycle `syscall` is presented. It drops in the first IDLE cycle after the service completes.
- An unsupported code produces `stall` = 0 and a 1-cycle `err` pulse in the cycle after sampling.
- print_char with `out_ready` tied high: `stall` is high for exactly 2 cycles.
- print_string costs 3 cycles per character minimum (REQ, WAIT, EMIT) with 1-cycle memory and `out_ready` held high.
- A `syscall` seen on the same edge the unit returns to IDLE is not serviced. Control must deassert `syscall` once `stall` drops.

## Test plan

- print_char: `$v0` = 11, `$a0` = 0x41, `out_ready` = 1 -> a single 'A' (0x41), `stall` high 2 cycles, then IDLE.
- print_int: `$a0` = -305, then `$a0` = 0, then `$a0` = 0x80000000 -> "-305", "0", "-2147483648" exactly. Also hold `out_ready` low for 5 cycles mid-number -> `out_data` stable, no lost or duplicate characters.
- print_string: memory at 0x100 holds "Hi!\0" (word 0x00216948), `$a0` = 0x100 -> 'H', 'i', '!' then IDLE. The same test with `$a0` = 0x101 -> "i!". The same test with `MAX_STR` = 2 -> "Hi" only.
- exit: `$v0` = 10 -> `halt` = 1 and `stall` = 1, held for 20 cycles with `syscall` toggling. Then `rst` -> `halt` = 0 and state IDLE.
- Unsupported code: `$v0` = 7 -> one-cycle `err` pulse, `stall` never high, no output.
- Asynchronous `rst` asserted mid-print_string, between clock edges -> `out_valid` and `stall` drop immediately. The next syscall (print_char 'Z') outputs only 'Z'.
